qick_div_arbiter: RTL and testbench
===================================

Name: qick_div_arbiter

Overview:
- Shares one pipelined restoring divider (`div_r`) between NREQ requesters, e.g. processor core, timing sequencer and peripheral port.
- Arbitrates round-robin and issues one division at a time.
- Routes the quotient and remainder back to the granted requester with a one-cycle done pulse.
- Resolves divide-by-zero locally, without launching the divider.

Parameters:
- NREQ, 2, number of requesters (legal 2..8).
- DW, 32, operand/result width; must match the divider's DW.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- req_i  in  NREQ  per-requester request; held high until the matching ack_o bit.
- a_i  in  NREQ*DW  packed dividends; slice k = a_i[k*DW +: DW].
- b_i  in  NREQ*DW  packed divisors, same packing.
- ack_o  out  NREQ  one-hot grant/accept pulse (combinational).
- done_o  out  NREQ  one-hot result-valid pulse (registered).
- quotient_o  out  DW  result quotient (registered).
- remainder_o  out  DW  result remainder (registered).
- dz_o  out  1  divide-by-zero flag; valid with done_o.
- busy_o  out  1  high in any state except IDLE.
- div_start_o  out  1  divider start pulse.
- div_a_o  out  DW  divider dividend.
- div_b_o  out  DW  divider divisor.
- div_ready_i  in  1  divider ready (low while working).
- div_quotient_i  in  DW  divider quotient.
- div_remainder_i  in  DW  divider remainder.

Behaviour:
- Reset: sampled at clk edge when rst_ni=0. Effects:
  - state=IDLE, rr_ptr=0.
  - ack_o, done_o, dz_o, busy_o, div_start_o = 0.
  - quotient_o, remainder_o, div_a_o, div_b_o = 0.
  - Reset mid-operation abandons the transaction: no done_o, and later div_ready_i is ignored.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - grant g = first k with req_i[k]=1, searching rr_ptr, rr_ptr+1, … mod NREQ.
  - ack_o[g]=1 in the same cycle; ack_o=0 in every other state.
  - On the edge: latch a, b, id=g; rr_ptr <= (g+1) mod NREQ.
  - If latched b==0, go to RESP with quotient={DW{1}}, remainder=a, dz=1.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): div_start_o=1; div_a_o/div_b_o = latched operands, held stable until the next ISSUE; then go to BUSY.
- BUSY:
  - Capture div_quotient_i/div_remainder_i on the first BUSY cycle with div_ready_i=1, then go to RESP.
  - div_ready_i is not examined in ISSUE, because the divider drops ready one cycle after start.
- RESP (1 cycle):
  - done_o[id]=1 and dz_o valid; then go to IDLE.
  - quotient_o/remainder_o/dz_o hold until the next RESP.
- Latency:
  - Accept at cycle T, start at T+1.
  - Divide-by-zero: done_o at T+1.
  - Normal: done_o one cycle after the first ready-high cycle in BUSY, i.e. T+3+N_PIPE for the default divider.
- Requests arriving outside IDLE wait; earliest ack is the cycle after RESP.
- No back-to-back overlap: at most one division outstanding.
- Requester dropping req_i before ack: request is lost, with no side effect.
- Arithmetic: unsigned by default; widths are DW throughout, with no truncation.

Optional Feature:
- Macro: QICK_DIV_SIGNED_EN.
- Defined (two's-complement signed division):
  - Operands issued to the divider as magnitudes.
  - Quotient negated when sign(a)≠sign(b); remainder takes the sign of a.
  - Most-negative / −1 returns quotient=most-negative value, remainder=0, dz=0.
  - Divide-by-zero still returns quotient={DW{1}}, remainder=a, dz=1.
  - Sign fix-up is applied in the BUSY→RESP capture, so latency is unchanged.
- Undefined: purely unsigned; no sign logic is synthesized.

Test Plan:
- Single request, req_i[0], a=100, b=7:
  - ack_o[0] in the request cycle, div_start_o next cycle with div_a_o=100, div_b_o=7.
  - done_o[0] one cycle after ready returns; quotient=14, remainder=2, dz=0.
- Divide-by-zero, req_i[1], a=0x1234, b=0:
  - done_o[1] at T+1; quotient=0xFFFFFFFF, remainder=0x1234, dz=1.
  - div_start_o never asserted.
- Round-robin, req_i[0] and req_i[1] both re-asserted immediately for 4 transactions:
  - grant order 0,1,0,1; each done_o bit matches its grant.
- Request during BUSY, req_i[1] raised while serving 0:
  - no ack_o until the cycle after done_o[0]; then ack_o[1].
  - the earlier request's result is unaffected.
- Reset mid-operation, rst_ni low for 1 cycle while in BUSY:
  - next cycle all outputs 0 and busy_o=0.
  - subsequent div_ready_i produces no done_o.
  - new request a=9, b=3 completes with quotient=3, remainder=0.
- Signedness, a=0xFFFFFF9C (−100), b=7:
  - with QICK_DIV_SIGNED_EN: quotient=0xFFFFFFF2 (−14), remainder=0xFFFFFFFE (−2).
  - without: quotient=613566742, remainder=2.
  - with macro, a=0x80000000, b=0xFFFFFFFF: quotient=0x80000000, remainder=0.

Source files
------------

// File: rtl/qick_div_arbiter.sv
// qick_div_arbiter
// ----------------
// Shares a single pipelined restoring divider among NREQ requesters.
// Requests are granted round-robin, one division is in flight at a time, and
// the result is returned to the granted requester with a one-cycle done pulse.
// A zero divisor is answered locally without launching the divider.
//
// Optional feature (compile-time macro QICK_DIV_SIGNED_EN):
//   defined   -> two's-complement signed division. Operand magnitudes go to the
//                divider, and the signs are restored when the result is captured.
//   undefined -> purely unsigned division. No sign logic is built.
//
// Parameters:
//   NREQ            number of requesters (2..8)
//   DW              operand/result width (must match the divider)
// Ports:
//   clk_i           clock
//   rst_ni          synchronous active-low reset
//   req_i           per-requester request, held until the matching ack_o bit
//   a_i / b_i       packed dividends/divisors, slice k = [k*DW +: DW]
//   ack_o           one-hot grant pulse (combinational, IDLE only)
//   done_o          one-hot result-valid pulse (registered)
//   quotient_o      result quotient (registered, held until the next result)
//   remainder_o     result remainder (registered, held until the next result)
//   dz_o            divide-by-zero flag, valid with done_o
//   busy_o          high whenever the FSM is not in IDLE
//   div_start_o     start pulse to the divider
//   div_a_o/div_b_o operands to the divider, stable from ISSUE onward
//   div_ready_i     divider ready (drops the cycle after a start)
//   div_quotient_i  divider quotient
//   div_remainder_i divider remainder

module qick_div_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*DW-1:0]   a_i,
    input  logic [NREQ*DW-1:0]   b_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [NREQ-1:0]      done_o,
    output logic [DW-1:0]        quotient_o,
    output logic [DW-1:0]        remainder_o,
    output logic                 dz_o,
    output logic                 busy_o,
    output logic                 div_start_o,
    output logic [DW-1:0]        div_a_o,
    output logic [DW-1:0]        div_b_o,
    input  logic                 div_ready_i,
    input  logic [DW-1:0]        div_quotient_i,
    input  logic [DW-1:0]        div_remainder_i
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   id;
    logic [PW-1:0]   grant;
    logic [PW-1:0]   next_ptr;
    logic            grant_valid;
    logic [PW:0]     idx;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;
    logic [DW-1:0]   mag_a;
    logic [DW-1:0]   mag_b;
    logic [DW-1:0]   res_q;
    logic [DW-1:0]   res_r;

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] v);
        logic [NREQ-1:0] r;
        r = '0;
        for (int k = 0; k < NREQ; k++) begin
            r[k] = (v == PW'(k));
        end
        return r;
    endfunction

    // The search walks downward from the farthest offset, so the requester
    // closest to rr_ptr is written last and wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (req_i[idx[PW-1:0]]) begin
                grant       = idx[PW-1:0];
                grant_valid = 1'b1;
            end
        end
    end

    assign next_ptr = (grant == PW'(NREQ - 1)) ? '0 : grant + PW'(1);

    // Pick the winning requester's operand slices.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant == PW'(k)) begin
                sel_a = a_i[k*DW +: DW];
                sel_b = b_i[k*DW +: DW];
            end
        end
    end

    // The grant is only visible in IDLE and while the block is out of reset,
    // so that a reset cycle never looks like an accept to a requester.
    always_comb begin
        ack_o = '0;
        if (state == IDLE && rst_ni && grant_valid) begin
            ack_o = onehot(grant);
        end
    end

`ifdef QICK_DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Remember the result signs at accept time. The divider only sees magnitudes.
    // The most-negative value maps onto itself as an unsigned magnitude, so
    // most-negative / -1 falls out correctly without a special case.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && grant_valid) begin
            neg_q <= sel_a[DW-1] ^ sel_b[DW-1];
            neg_r <= sel_a[DW-1];
        end
    end

    assign mag_a = sel_a[DW-1] ? -sel_a : sel_a;
    assign mag_b = sel_b[DW-1] ? -sel_b : sel_b;
    assign res_q = neg_q ? -div_quotient_i  : div_quotient_i;
    assign res_r = neg_r ? -div_remainder_i : div_remainder_i;
`else
    assign mag_a = sel_a;
    assign mag_b = sel_b;
    assign res_q = div_quotient_i;
    assign res_r = div_remainder_i;
`endif

    // Main FSM. All outputs except ack_o are registered here.
    // div_start_o and done_o default low so that they last exactly one cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            id          <= '0;
            done_o      <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
            dz_o        <= 1'b0;
            busy_o      <= 1'b0;
            div_start_o <= 1'b0;
            div_a_o     <= '0;
            div_b_o     <= '0;
        end else begin
            div_start_o <= 1'b0;
            done_o      <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        id     <= grant;
                        rr_ptr <= next_ptr;
                        busy_o <= 1'b1;
                        if (sel_b == '0) begin
                            // Divide-by-zero is answered here, and the divider stays idle.
                            quotient_o  <= '1;
                            remainder_o <= sel_a;
                            dz_o        <= 1'b1;
                            done_o      <= onehot(grant);
                            state       <= RESP;
                        end else begin
                            div_a_o     <= mag_a;
                            div_b_o     <= mag_b;
                            div_start_o <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                // div_ready_i is still high from the previous idle period
                // during ISSUE, so it is not looked at until BUSY.
                ISSUE: begin
                    state <= BUSY;
                end
                BUSY: begin
                    if (div_ready_i) begin
                        quotient_o  <= res_q;
                        remainder_o <= res_r;
                        dz_o        <= 1'b0;
                        done_o      <= onehot(id);
                        state       <= RESP;
                    end
                end
                RESP: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qick_div_arbiter.sv
// tb_qick_div_arbiter
// -------------------
// Directed testbench for qick_div_arbiter (NREQ=2, DW=32).
// A small behavioural divider model sits on the divider ports. The model
// lowers ready the cycle after a start and raises it again N_PIPE cycles later.
// Expected results are hand-computed constants. The signed expectations are
// chosen by QICK_DIV_SIGNED_EN.

module tb_qick_div_arbiter;

    localparam int NREQ   = 2;
    localparam int DW     = 32;
    localparam int N_PIPE = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  a_bus;
    logic [NREQ*DW-1:0]  b_bus;
    logic [NREQ-1:0]     ack;
    logic [NREQ-1:0]     done;
    logic [DW-1:0]       quotient;
    logic [DW-1:0]       remainder;
    logic                dz;
    logic                busy;
    logic                div_start;
    logic [DW-1:0]       div_a;
    logic [DW-1:0]       div_b;
    logic                div_ready = 1'b1;
    logic [DW-1:0]       div_q = '0;
    logic [DW-1:0]       div_r = '0;

    int vectors     = 0;
    int miscompares = 0;
    int div_cnt     = 0;
    int start_count = 0;

    always #5 clk = ~clk;

    qick_div_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_i           (req),
        .a_i             (a_bus),
        .b_i             (b_bus),
        .ack_o           (ack),
        .done_o          (done),
        .quotient_o      (quotient),
        .remainder_o     (remainder),
        .dz_o            (dz),
        .busy_o          (busy),
        .div_start_o     (div_start),
        .div_a_o         (div_a),
        .div_b_o         (div_b),
        .div_ready_i     (div_ready),
        .div_quotient_i  (div_q),
        .div_remainder_i (div_r)
    );

    // Behavioural stand-in for the shared divider.
    always @(posedge clk) begin
        if (div_start) begin
            start_count <= start_count + 1;
            div_ready   <= 1'b0;
            div_cnt     <= N_PIPE;
            div_q       <= (div_b == '0) ? '1 : div_a / div_b;
            div_r       <= (div_b == '0) ? div_a : div_a % div_b;
        end else if (div_cnt > 1) begin
            div_cnt <= div_cnt - 1;
        end else if (div_cnt == 1) begin
            div_cnt   <= 0;
            div_ready <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [31:0] a, input logic [31:0] b);
        a_bus[k*DW +: DW] = a;
        b_bus[k*DW +: DW] = b;
        req[k]            = 1'b1;
        #1;
    endtask

    task automatic waitDone(output int n);
        n = 0;
        while (done == '0 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("done_seen", 32'(done != '0), 32'd1);
    endtask

    initial begin
        int n;
        int s0;
        logic saw;
        logic [NREQ-1:0] grant;

        rst_n = 1'b0;
        req   = '0;
        a_bus = '0;
        b_bus = '0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_ack",   32'(ack), 32'd0);
        checkOutput("rst_done",  32'(done), 32'd0);
        checkOutput("rst_busy",  32'(busy), 32'd0);
        checkOutput("rst_start", 32'(div_start), 32'd0);
        checkOutput("rst_dz",    32'(dz), 32'd0);
        checkOutput("rst_quot",  quotient, 32'd0);
        checkOutput("rst_rem",   remainder, 32'd0);
        checkOutput("rst_diva",  div_a, 32'd0);
        checkOutput("rst_divb",  div_b, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request 100 / 7
        $display("[TB] single request");
        applyStimulus(0, 32'd100, 32'd7);
        checkOutput("t1_ack", 32'(ack), 32'd1);
        tick();
        req[0] = 1'b0;
        checkOutput("t1_start", 32'(div_start), 32'd1);
        checkOutput("t1_diva",  div_a, 32'd100);
        checkOutput("t1_divb",  div_b, 32'd7);
        checkOutput("t1_busy",  32'(busy), 32'd1);
        checkOutput("t1_ack_issue", 32'(ack), 32'd0);
        waitDone(n);
        checkOutput("t1_latency", 32'(n), 32'(N_PIPE + 2));
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_quot", quotient, 32'd14);
        checkOutput("t1_rem",  remainder, 32'd2);
        checkOutput("t1_dz",   32'(dz), 32'd0);
        tick();
        checkOutput("t1_done_pulse", 32'(done), 32'd0);
        checkOutput("t1_idle_busy",  32'(busy), 32'd0);
        checkOutput("t1_hold_quot",  quotient, 32'd14);

        // Divide-by-zero on requester 1
        $display("[TB] divide by zero");
        s0 = start_count;
        applyStimulus(1, 32'h1234, 32'd0);
        checkOutput("t2_ack", 32'(ack), 32'd2);
        tick();
        req[1] = 1'b0;
        checkOutput("t2_done",  32'(done), 32'd2);
        checkOutput("t2_quot",  quotient, 32'hFFFF_FFFF);
        checkOutput("t2_rem",   remainder, 32'h1234);
        checkOutput("t2_dz",    32'(dz), 32'd1);
        checkOutput("t2_start", 32'(div_start), 32'd0);
        tick();
        checkOutput("t2_no_start", 32'(start_count), 32'(s0));
        checkOutput("t2_done_pulse", 32'(done), 32'd0);

        // Round-robin with both requests held high
        $display("[TB] round robin");
        applyStimulus(0, 32'd50, 32'd5);
        applyStimulus(1, 32'd1000, 32'd33);
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (ack == '0 && n < 100) begin
                tick();
                n++;
            end
            grant = ack;
            checkOutput("t3_grant", 32'(grant), (t % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            waitDone(n);
            checkOutput("t3_done_id", 32'(done), 32'(grant));
            checkOutput("t3_quot", quotient, (t % 2 == 0) ? 32'd10 : 32'd30);
            checkOutput("t3_rem",  remainder, (t % 2 == 0) ? 32'd0 : 32'd10);
        end
        req = '0;
        tick();

        // Request raised while another is being served
        $display("[TB] request during busy");
        applyStimulus(0, 32'd77, 32'd7);
        checkOutput("t4_ack0", 32'(ack), 32'd1);
        tick();
        req[0] = 1'b0;
        tick();
        applyStimulus(1, 32'd20, 32'd6);
        saw = 1'b0;
        n = 0;
        while (done == '0 && n < 100) begin
            if (ack != '0) saw = 1'b1;
            tick();
            n++;
        end
        checkOutput("t4_no_early_ack", 32'(saw), 32'd0);
        checkOutput("t4_done0", 32'(done), 32'd1);
        checkOutput("t4_quot0", quotient, 32'd11);
        checkOutput("t4_rem0",  remainder, 32'd0);
        checkOutput("t4_ack_resp", 32'(ack), 32'd0);
        tick();
        checkOutput("t4_ack1", 32'(ack), 32'd2);
        tick();
        req[1] = 1'b0;
        waitDone(n);
        checkOutput("t4_done1", 32'(done), 32'd2);
        checkOutput("t4_quot1", quotient, 32'd3);
        checkOutput("t4_rem1",  remainder, 32'd2);
        tick();

        // Reset while BUSY
        $display("[TB] reset mid-operation");
        applyStimulus(0, 32'd200, 32'd9);
        tick();
        req[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("t5_busy",  32'(busy), 32'd0);
        checkOutput("t5_done",  32'(done), 32'd0);
        checkOutput("t5_start", 32'(div_start), 32'd0);
        checkOutput("t5_quot",  quotient, 32'd0);
        checkOutput("t5_rem",   remainder, 32'd0);
        checkOutput("t5_diva",  div_a, 32'd0);
        saw = 1'b0;
        repeat (10) begin
            if (done != '0) saw = 1'b1;
            tick();
        end
        checkOutput("t5_no_stale_done", 32'(saw), 32'd0);
        applyStimulus(0, 32'd9, 32'd3);
        checkOutput("t5_ack", 32'(ack), 32'd1);
        tick();
        req[0] = 1'b0;
        waitDone(n);
        checkOutput("t5_done_new", 32'(done), 32'd1);
        checkOutput("t5_quot_new", quotient, 32'd3);
        checkOutput("t5_rem_new",  remainder, 32'd0);
        tick();

        // Signedness
        $display("[TB] signedness");
        applyStimulus(1, 32'hFFFF_FF9C, 32'd7);
        tick();
        req[1] = 1'b0;
        waitDone(n);
`ifdef QICK_DIV_SIGNED_EN
        checkOutput("t6_quot", quotient, 32'hFFFF_FFF2);
        checkOutput("t6_rem",  remainder, 32'hFFFF_FFFE);
`else
        checkOutput("t6_quot", quotient, 32'd613566742);
        checkOutput("t6_rem",  remainder, 32'd2);
`endif
        checkOutput("t6_dz", 32'(dz), 32'd0);
        tick();
        applyStimulus(0, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        req[0] = 1'b0;
        waitDone(n);
`ifdef QICK_DIV_SIGNED_EN
        checkOutput("t6_minneg_quot", quotient, 32'h8000_0000);
        checkOutput("t6_minneg_rem",  remainder, 32'd0);
`else
        checkOutput("t6_minneg_quot", quotient, 32'd0);
        checkOutput("t6_minneg_rem",  remainder, 32'h8000_0000);
`endif
        checkOutput("t6_minneg_dz", 32'(dz), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
